mvu_pe_fold_ctrl: RTL
=====================

# mvu_pe_fold_ctrl

Folding controller for a single MVU processing element built around the binary SIMD multiplier. It accepts an input activation vector as SF beats of SIMD lanes and buffers it. It then replays the vector NF times, generating weight-memory addresses and accumulating SIMD-lane binary products. It emits one accumulated dot product per neuron fold on a valid/ready stream, sitting between the input activation stream and the PE output stream of the MVU.

## Interface
- SIMD, 4, lanes per beat
- TSrcI, 1, activation lane width (bits)
- TW, 4, weight lane width (bits); TSrcI==1 or TW==1 required
- TDstI, 16, accumulator/output width (bits)
- SF, 2, synapse fold: beats per input vector (≥1)
- NF, 2, neuron fold: outputs per input vector (≥1)
- aclk  in  1  clock, rising edge
- aresetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  activation beat valid
- in_ready  out  1  activation beat accepted when in_valid&&in_ready
- in_data  in  SIMD*TSrcI  activation lanes, lane i at [i*TSrcI +: TSrcI]
- wmem_addr  out  $clog2(SF*NF) (min 1)  weight address, combinational from counters
- wmem_data  in  SIMD*TW  weight lanes, combinational read of wmem_addr, same cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  TDstI  accumulated dot product, two's complement

## Operation
- Lane product, binary rule: TW==1 → wgt==1 ? act : -act; otherwise TSrcI==1 → act==1 ? wgt : -wgt. Treat the operand as unsigned and sign-extend the negated product to TDstI.
- beat_sum = sum of SIMD lane products; acc_next = acc + beat_sum, modulo 2^TDstI (wraps, no saturation).
- Counters: sf (0..SF-1), nf (0..NF-1); wmem_addr = nf*SF + sf.
- States:
  - FILL (nf==0): beat source is in_data; each accepted beat is written to buf[sf].
  - REPLAY (nf>0): beat source is buf[sf]; in_ready=0.
- advance = beat available (FILL: in_valid; REPLAY: 1) && !(sf==SF-1 && out_valid && !out_ready).
- FILL: in_ready = !(sf==SF-1 && out_valid && !out_ready).
- On advance with sf<SF-1: acc<=acc_next; sf++.
- On advance with sf==SF-1:
  - out_data<=acc_next; out_valid<=1; acc<=0; sf<=0.
  - If nf==NF-1: nf<=0 and go to FILL. Otherwise nf++ and go to REPLAY.
- Output: out_valid clears on out_valid&&out_ready unless a new result loads the same cycle (loading wins).
- NF==1: never enters REPLAY. SF==1: every beat produces a result.
- Reset state: FILL, sf=nf=0, acc=0, out_valid=0, out_data=0, buffer contents don't-care; in_ready=1 once aresetn is high.
- Reset mid-vector discards the partial accumulation and buffer; the next accepted beat is treated as sf=0 of a new vector.

## Timing
- Throughput: one beat per cycle when unstalled, so SF*NF cycles per input vector. FILL is limited by in_valid.
- Latency: result visible on out_data/out_valid the cycle after the last beat (sf==SF-1) of a fold.
- Back-to-back folds: no bubble if out_ready=1. If out_ready=0, only the final beat of the next fold stalls; earlier beats continue accumulating.
- in_data and wmem_data are sampled in the same cycle as the handshake. wmem_data must be stable combinationally for the current wmem_addr.
- Buffer write (FILL) and read (REPLAY) never occur in the same cycle.

## Structure
- Shared package mvu_pkg:
  - the state enum (FILL, REPLAY);
  - function clog2_min1;
  - parameter-check constants for TSrcI==1||TW==1.
- Sub-module mvu_pe_simd_lane_sum: combinational SIMD-lane product-and-sum. Instantiates the binary SIMD multiplier per lane and produces the TDstI beat_sum.
- Activation buffer: SF×(SIMD*TSrcI) register array inside the controller.

## Test plan
- SF=2, NF=2, TSrcI=1, TW=4. Stimulus: all act lanes 1, all weights 1, two beats. Required: out_data 8, then 8 again on the replay; wmem_addr sequence 0,1,2,3; in_ready=0 during replay.
- Same config, act lanes all 0, weights 3. Required: outputs −24 (0xFFE8) twice, showing the negation path and sign extension.
- TDstI=4, weights 7, act 1, SF=2. Required: sum 56 wraps, out_data=8 (56 mod 16).
- out_ready=0 held for 5 cycles after the first result. Required: controller stalls at sf==SF-1 of fold 2, first result held stable, no result lost; release yields the second result next cycle.
- in_valid gapped every other cycle in FILL. Required: accumulation unaffected, same outputs as the unstalled run.
- aresetn asserted after beat 1 of 2, then a fresh 2-beat vector. Required: out_valid=0 during reset; first result reflects only the fresh vector.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared types and helpers for the MVU processing-element fold controller.
package mvu_pkg;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_REPLAY = 1'b1
    } fold_state_e;

    // The binary multiplier needs at least one operand to be a single bit.
    localparam int unsigned BIN_WIDTH = 1;

    function automatic bit binary_ok(input int unsigned tsrci, input int unsigned tw);
        return (tsrci == BIN_WIDTH) || (tw == BIN_WIDTH);
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvu_pe_simd_lane_sum.sv
// Combinational SIMD-lane binary products summed into one TDstI-wide beat sum.
module mvu_pe_simd_lane_sum #(
    parameter int unsigned SIMD  = 4,
    parameter int unsigned TSrcI = 1,
    parameter int unsigned TW    = 4,
    parameter int unsigned TDstI = 16
) (
    input  logic [SIMD*TSrcI-1:0] i_act,
    input  logic [SIMD*TW-1:0]    i_wgt,
    output logic [TDstI-1:0]      o_sum
);

    logic [TDstI-1:0] w_prod [SIMD];

    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        logic [TDstI-1:0] w_op;
        logic             w_pos;
        // The single-bit operand selects +/- of the other, zero-extended, operand.
        if (TW == 1) begin : g_wgt_bin
            assign w_op  = TDstI'(i_act[i*TSrcI +: TSrcI]);
            assign w_pos = i_wgt[i*TW];
        end else begin : g_act_bin
            assign w_op  = TDstI'(i_wgt[i*TW +: TW]);
            assign w_pos = i_act[i*TSrcI];
        end
        assign w_prod[i] = w_pos ? w_op : -w_op;
    end

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            o_sum = o_sum + w_prod[i];
        end
    end

endmodule

// File: rtl/mvu_pe_fold_ctrl.sv
// MVU PE fold controller: buffers one SF-beat activation vector and replays it
// NF times, emitting one accumulated dot product per neuron fold.
module mvu_pe_fold_ctrl
    import mvu_pkg::*;
#(
    parameter int unsigned SIMD  = 4,
    parameter int unsigned TSrcI = 1,
    parameter int unsigned TW    = 4,
    parameter int unsigned TDstI = 16,
    parameter int unsigned SF    = 2,
    parameter int unsigned NF    = 2
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SIMD*TSrcI-1:0]            in_data,
    output logic [clog2_min1(SF*NF)-1:0]     wmem_addr,
    input  logic [SIMD*TW-1:0]               wmem_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TDstI-1:0]                 out_data
);

    localparam int unsigned AW  = clog2_min1(SF*NF);
    localparam int unsigned SFW = clog2_min1(SF);
    localparam int unsigned NFW = clog2_min1(NF);
    localparam int unsigned DW  = SIMD*TSrcI;

    if (!binary_ok(TSrcI, TW)) begin : g_bad_cfg
        $error("mvu_pe_fold_ctrl: TSrcI or TW must be 1");
    end

    fold_state_e      r_state;
    logic [SFW-1:0]   r_sf;
    logic [NFW-1:0]   r_nf;
    logic [TDstI-1:0] r_acc;
    logic             r_out_valid;
    logic [TDstI-1:0] r_out_data;
    logic [DW-1:0]    r_buf [SF];

    logic             w_fill;
    logic             w_last_sf;
    logic             w_last_nf;
    logic             w_stall;
    logic             w_adv;
    logic [DW-1:0]    w_beat;
    logic [TDstI-1:0] w_beat_sum;
    logic [TDstI-1:0] w_acc_next;

    assign w_fill     = (r_state == ST_FILL);
    assign w_last_sf  = (r_sf == SFW'(SF - 1));
    assign w_last_nf  = (r_nf == NFW'(NF - 1));
    // Only the fold-closing beat must wait for a free output register.
    assign w_stall    = w_last_sf && r_out_valid && !out_ready;
    assign w_adv      = (w_fill ? in_valid : 1'b1) && !w_stall;
    assign w_beat     = w_fill ? in_data : r_buf[r_sf];
    assign w_acc_next = r_acc + w_beat_sum;

    assign in_ready   = w_fill && !w_stall;
    assign wmem_addr  = AW'(r_nf) * AW'(SF) + AW'(r_sf);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    mvu_pe_simd_lane_sum #(
        .SIMD  (SIMD),
        .TSrcI (TSrcI),
        .TW    (TW),
        .TDstI (TDstI)
    ) u_lane_sum (
        .i_act (w_beat),
        .i_wgt (wmem_data),
        .o_sum (w_beat_sum)
    );

    // Activation buffer holds no control state, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (w_fill && w_adv) begin
            r_buf[r_sf] <= in_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_FILL;
            r_sf        <= '0;
            r_nf        <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_adv) begin
                if (!w_last_sf) begin
                    r_acc <= w_acc_next;
                    r_sf  <= r_sf + SFW'(1);
                end else begin
                    r_out_data  <= w_acc_next;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_sf        <= '0;
                    if (w_last_nf) begin
                        r_nf    <= '0;
                        r_state <= ST_FILL;
                    end else begin
                        r_nf    <= r_nf + NFW'(1);
                        r_state <= ST_REPLAY;
                    end
                end
            end
        end
    end

endmodule
